// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed data memory for the MEM stage.
// Byte/half/word loads and stores with sign/zero extension, byte-lane writes,
// alignment error reporting and a fixed access latency behind a valid/ready
// request and a single-cycle response pulse. One request in flight at a time.
module data_mem_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_signed_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              write_q;
  logic [1:0]        size_q;
  logic              signed_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accWrite;
  logic [1:0]        accSize;
  logic              accSigned;
  logic [ADDR_W-1:0] accAddr;
  logic [DATA_W-1:0] accWdata;
  logic [1:0]        accLane;
  logic [4:0]        accShift;
  logic              accErr;
  logic              enterResp;
  logic [DATA_W-1:0] rdWord;
  logic [DATA_W-1:0] rdShifted;
  logic [DATA_W-1:0] loadData;
  logic [DATA_W-1:0] laneMask;
  logic [DATA_W-1:0] mergedWord;

  // State, counter and request latch; the request fields are captured on accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      write_q  <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == IDLE && req_valid_i) begin
        write_q  <= req_write_i;
        size_q   <= req_size_i;
        signed_q <= req_signed_i;
        addr_q   <= req_addr_i;
        wdata_q  <= req_wdata_i;
      end
    end
  end

  // Next state: BUSY counts down the remaining latency, RESP always lasts one cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = BUSY;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Handshake outputs follow the state directly
  always_comb begin
    req_ready_o  = (state_q == IDLE);
    resp_valid_o = (state_q == RESP);
    resp_rdata_o = resp_rdata_q;
    resp_err_o   = resp_err_q;
  end

  // With LATENCY=1 the access completes on the accept edge, before the latch
  // holds anything, so the live request fields are used while still in IDLE
  always_comb begin
    accWrite  = (state_q == IDLE) ? req_write_i  : write_q;
    accSize   = (state_q == IDLE) ? req_size_i   : size_q;
    accSigned = (state_q == IDLE) ? req_signed_i : signed_q;
    accAddr   = (state_q == IDLE) ? req_addr_i   : addr_q;
    accWdata  = (state_q == IDLE) ? req_wdata_i  : wdata_q;
    accLane   = accAddr[1:0];
    accShift  = {accLane, 3'b000};
    enterResp = (state_d == RESP);
    accErr    = (accSize == 2'b11) ||
                (accSize == 2'b01 && accLane[0]) ||
                (accSize == 2'b10 && accLane != 2'b00);
  end

  // Lane selection, extension for loads and merge of store lanes into the old word
  always_comb begin
    rdWord    = mem[accAddr[ADDR_W-1:2]];
    rdShifted = rdWord >> accShift;
    loadData  = rdWord;
    laneMask  = '1;
    case (accSize)
      2'b00: begin
        loadData = {{(DATA_W-8){accSigned & rdShifted[7]}}, rdShifted[7:0]};
        laneMask = DATA_W'(8'hFF) << accShift;
      end
      2'b01: begin
        loadData = {{(DATA_W-16){accSigned & rdShifted[15]}}, rdShifted[15:0]};
        laneMask = DATA_W'(16'hFFFF) << accShift;
      end
      default: begin
        loadData = rdWord;
        laneMask = '1;
      end
    endcase
    mergedWord = (rdWord & ~laneMask) | ((accWdata << accShift) & laneMask);
  end

  // Memory array: written on the edge that enters RESP, never cleared by reset
  always_ff @(posedge clk_i) begin
    if (!rst_i && enterResp && accWrite && !accErr) begin
      mem[accAddr[ADDR_W-1:2]] <= mergedWord;
    end
  end

  // Response data/error captured on the edge entering RESP and held until the next one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else if (enterResp) begin
      resp_err_q   <= accErr;
      resp_rdata_q <= (accWrite || accErr) ? '0 : loadData;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl: three instances with latencies 1, 3 and 4 share
// the request fields; each has its own valid line and outputs. Directed cases
// plus random traffic are checked against a word-array reference model.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  reqValid;
  logic [2:0]  reqReady;
  logic [2:0]  respValid;
  logic [2:0]  respErr;
  logic [31:0] respRdata [3];
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [8:0]  reqAddr;
  logic [31:0] reqWdata;

  int          total = 0;
  int          bad = 0;
  logic [31:0] modelMem [3][128];
  logic [31:0] lastRdata;
  logic        lastErr;

  always #5 clk = ~clk;

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .LATENCY(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid[0]), .req_ready_o(reqReady[0]),
    .req_write_i(reqWrite), .req_size_i(reqSize), .req_signed_i(reqSigned),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .resp_valid_o(respValid[0]),
    .resp_rdata_o(respRdata[0]), .resp_err_o(respErr[0]));

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .LATENCY(3)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid[1]), .req_ready_o(reqReady[1]),
    .req_write_i(reqWrite), .req_size_i(reqSize), .req_signed_i(reqSigned),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .resp_valid_o(respValid[1]),
    .resp_rdata_o(respRdata[1]), .resp_err_o(respErr[1]));

  data_mem_ctrl #(.DATA_W(32), .ADDR_W(9), .LATENCY(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(reqValid[2]), .req_ready_o(reqReady[2]),
    .req_write_i(reqWrite), .req_size_i(reqSize), .req_signed_i(reqSigned),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .resp_valid_o(respValid[2]),
    .resp_rdata_o(respRdata[2]), .resp_err_o(respErr[2]));

  function automatic int latOf(input int d);
    return (d == 0) ? 1 : (d == 1) ? 3 : 4;
  endfunction

  // Reference store: replace the addressed byte/half/word in the old word
  function automatic logic [31:0] modelStore(input logic [31:0] word, input logic [1:0] sz,
                                             input logic [1:0] lane, input logic [31:0] wd);
    logic [31:0] r;
    r = word;
    case (sz)
      2'b00:   r[int'(lane) * 8 +: 8]  = wd[7:0];
      2'b01:   r[int'(lane) * 8 +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // Reference load: plain arithmetic on the unsigned field value
  function automatic logic [31:0] modelLoad(input logic [31:0] word, input logic [1:0] sz,
                                            input logic sg, input logic [1:0] lane);
    longint v;
    v = longint'(word) >> (8 * int'(lane));
    case (sz)
      2'b00: begin
        v = v % 256;
        if (sg && v >= 128) v = v - 256;
      end
      2'b01: begin
        v = v % 65536;
        if (sg && v >= 32768) v = v - 65536;
      end
      default: v = longint'(word);
    endcase
    return 32'(v);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request on instance d; optionally keeps valid high with a junk store while busy
  task automatic applyStimulus(input int d, input logic w, input logic [1:0] sz, input logic sg,
                               input logic [8:0] a, input logic [31:0] wd, input bit spam);
    int          cyc;
    bit          seen;
    logic [31:0] expData;
    logic        expErr;
    logic [6:0]  idx;
    logic [1:0]  lane;
    @(negedge clk);
    checkOutput("ready_idle", 32'(reqReady[d]), 32'd1);
    reqWrite  = w;
    reqSize   = sz;
    reqSigned = sg;
    reqAddr   = a;
    reqWdata  = wd;
    reqValid[d] = 1'b1;
    idx  = a[8:2];
    lane = a[1:0];
    expErr  = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && lane != 2'b00);
    expData = 32'd0;
    if (!expErr) begin
      if (w) modelMem[d][idx] = modelStore(modelMem[d][idx], sz, lane, wd);
      else   expData = modelLoad(modelMem[d][idx], sz, sg, lane);
    end
    @(posedge clk);
    @(negedge clk);
    if (spam) begin
      reqWrite = 1'b1;
      reqSize  = 2'b10;
      reqAddr  = 9'h040;
      reqWdata = 32'hBAD0BAD0;
    end else begin
      reqValid[d] = 1'b0;
    end
    cyc  = 1;
    seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (respValid[d]) begin
        seen = 1'b1;
      end else begin
        checkOutput("ready_busy", 32'(reqReady[d]), 32'd0);
        @(negedge clk);
        cyc++;
      end
    end
    reqValid[d] = 1'b0;
    checkOutput("latency", 32'(cyc), 32'(latOf(d)));
    checkOutput("ready_resp", 32'(reqReady[d]), 32'd0);
    checkOutput("rdata", respRdata[d], expData);
    checkOutput("err", 32'(respErr[d]), 32'(expErr));
    lastRdata = respRdata[d];
    lastErr   = respErr[d];
  endtask

  initial begin
    int          seenAbort;
    int          d;
    logic [1:0]  sz;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 128; j++)
        modelMem[i][j] = 32'd0;
    rst = 1'b1;
    reqValid  = 3'b000;
    reqWrite  = 1'b0;
    reqSize   = 2'b00;
    reqSigned = 1'b0;
    reqAddr   = 9'd0;
    reqWdata  = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of every instance
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst_ready", 32'(reqReady[i]), 32'd1);
      checkOutput("rst_valid", 32'(respValid[i]), 32'd0);
      checkOutput("rst_rdata", respRdata[i], 32'd0);
      checkOutput("rst_err", 32'(respErr[i]), 32'd0);
    end

    // Word store/load, sub-word store, byte and half loads, alignment errors
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 9'h018, 32'hDEADBEEF, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 9'h018, 32'd0, 1'b0);
    checkOutput("t1_lw", lastRdata, 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 2'b00, 1'b0, 9'h019, 32'h0000007F, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 9'h018, 32'd0, 1'b0);
    checkOutput("t2_lw", lastRdata, 32'hDEAD7FEF);
    applyStimulus(0, 1'b0, 2'b00, 1'b1, 9'h01B, 32'd0, 1'b0);
    checkOutput("t2_lb", lastRdata, 32'hFFFFFFDE);
    applyStimulus(0, 1'b0, 2'b00, 1'b0, 9'h01B, 32'd0, 1'b0);
    checkOutput("t2_lbu", lastRdata, 32'h000000DE);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 9'h01A, 32'd0, 1'b0);
    checkOutput("t3_lh", lastRdata, 32'hFFFFDEAD);
    applyStimulus(0, 1'b0, 2'b01, 1'b0, 9'h01A, 32'd0, 1'b0);
    checkOutput("t3_lhu", lastRdata, 32'h0000DEAD);
    applyStimulus(0, 1'b0, 2'b01, 1'b1, 9'h019, 32'd0, 1'b0);
    checkOutput("t3_lh_mis_err", 32'(lastErr), 32'd1);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 9'h01A, 32'h11223344, 1'b0);
    checkOutput("t3_sw_mis_err", 32'(lastErr), 32'd1);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 9'h018, 32'd0, 1'b0);
    checkOutput("t3_reread", lastRdata, 32'hDEAD7FEF);

    // Latency 4 with requests held during the busy window; they must be dropped
    applyStimulus(2, 1'b0, 2'b10, 1'b0, 9'h018, 32'd0, 1'b1);
    applyStimulus(2, 1'b0, 2'b10, 1'b0, 9'h040, 32'd0, 1'b0);
    checkOutput("t4_ignored", lastRdata, 32'd0);

    // Latency 3 store aborted by a reset pulse the cycle after accept
    @(negedge clk);
    checkOutput("t5_ready", 32'(reqReady[1]), 32'd1);
    reqWrite = 1'b1;
    reqSize  = 2'b10;
    reqAddr  = 9'h000;
    reqWdata = 32'h12345678;
    reqValid[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reqValid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seenAbort = 0;
    repeat (6) begin
      if (respValid[1]) seenAbort = 1;
      @(negedge clk);
    end
    checkOutput("t5_no_resp", 32'(seenAbort), 32'd0);
    applyStimulus(1, 1'b0, 2'b10, 1'b0, 9'h000, 32'd0, 1'b0);
    checkOutput("t5_aborted", lastRdata, 32'd0);

    // Last word versus word 0, and the illegal size
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 9'h1FC, 32'hA5A55A5A, 1'b0);
    applyStimulus(0, 1'b1, 2'b10, 1'b0, 9'h000, 32'h0BADF00D, 1'b0);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 9'h1FC, 32'd0, 1'b0);
    checkOutput("t6_last", lastRdata, 32'hA5A55A5A);
    applyStimulus(0, 1'b0, 2'b10, 1'b0, 9'h000, 32'd0, 1'b0);
    checkOutput("t6_first", lastRdata, 32'h0BADF00D);
    applyStimulus(0, 1'b0, 2'b11, 1'b0, 9'h000, 32'd0, 1'b0);
    checkOutput("t6_size11", 32'(lastErr), 32'd1);

    // Random traffic across all three instances
    for (int k = 0; k < 60; k++) begin
      d  = int'($urandom_range(0, 2));
      sz = 2'($urandom_range(0, 3));
      applyStimulus(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                    9'($urandom_range(0, 511)), $urandom, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
